// File: rtl/connect_split_pkg.sv
// Shared constants for the connect_split / connect_join router family:
// packet width and where the destination field sits inside a packet.
package connect_split_pkg;

  localparam int PACKET_WIDTH     = 32;
  localparam int SPLIT_DEST_LSB   = 0;
  localparam int SPLIT_DEST_WIDTH = 4;
  localparam int SPLIT_CNT_WIDTH  = 16;
  localparam int SPLIT_MAX_PORTS  = 16;

endpackage

// File: rtl/connect_split_slot.sv
// One-entry output holding slot for a single connect_split channel.
// Reload while draining keeps the slot full, giving one packet per cycle.
module split_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  send_ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  free
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && send_ready) begin
      valid <= 1'b0;
    end
  end

  // A slot that is being drained this cycle can take a new packet.
  assign free = !valid || send_ready;

endmodule

// File: rtl/connect_split.sv
// 1-to-N packet demultiplexer: routes each input packet to the channel named
// by its destination field; out-of-range packets are consumed and counted.
module connect_split
  import connect_split_pkg::*;
#(
  parameter int DATA_WIDTH  = PACKET_WIDTH,
  parameter int CONNECT_NUM = 3,
  parameter int DEST_LSB    = SPLIT_DEST_LSB,
  parameter int DEST_WIDTH  = SPLIT_DEST_WIDTH,
  parameter int CNT_WIDTH   = SPLIT_CNT_WIDTH
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              RECEIVE_VALID,
  output logic                              RECEIVE_READY,
  input  logic [DATA_WIDTH-1:0]             RECEIVE_DATA,
  output logic [CONNECT_NUM-1:0]            SEND_VALID,
  input  logic [CONNECT_NUM-1:0]            SEND_READY,
  output logic [DATA_WIDTH*CONNECT_NUM-1:0] SEND_DATA,
  output logic [CNT_WIDTH-1:0]              DROP_COUNT
);

  localparam int unsigned NUM_U = CONNECT_NUM;

  logic [DEST_WIDTH-1:0]  dest;
  logic [31:0]            dest_ext;
  logic                   in_range;
  logic                   free_sel;
  logic                   accept;
  logic                   drop;
  logic [CONNECT_NUM-1:0] load;
  logic [CONNECT_NUM-1:0] free;
  logic [CNT_WIDTH-1:0]   drop_cnt;

  // Ready depends on the destination field and SEND_READY, never on RECEIVE_VALID.
  always_comb begin
    dest     = RECEIVE_DATA[DEST_LSB +: DEST_WIDTH];
    dest_ext = 32'(dest);
    in_range = dest_ext < NUM_U;
    free_sel = 1'b0;
    load     = '0;
    for (int unsigned i = 0; i < NUM_U; i++) begin
      if (dest_ext == i) free_sel = free[i];
    end
    RECEIVE_READY = !RST && (in_range ? free_sel : 1'b1);
    accept        = RECEIVE_VALID && RECEIVE_READY;
    drop          = accept && !in_range;
    for (int unsigned i = 0; i < NUM_U; i++) begin
      load[i] = accept && in_range && (dest_ext == i);
    end
  end

  for (genvar g = 0; g < CONNECT_NUM; g++) begin : g_slot
    split_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .CLK       (CLK),
      .RST       (RST),
      .load      (load[g]),
      .load_data (RECEIVE_DATA),
      .send_ready(SEND_READY[g]),
      .valid     (SEND_VALID[g]),
      .data      (SEND_DATA[DATA_WIDTH*g +: DATA_WIDTH]),
      .free      (free[g])
    );
  end

  // Saturating drop counter: sticks at all-ones rather than wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end

  assign DROP_COUNT = drop_cnt;

endmodule

// File: tb/tb_connect_split.sv
// Scoreboard bench for connect_split: expected packets are queued per channel
// when accepted at the input and matched when the channel hands them off.
module tb_connect_split;
  import connect_split_pkg::*;

  localparam int DW = PACKET_WIDTH;
  localparam int N  = 3;

  logic            CLK = 1'b0;
  logic            RST;
  logic            RECEIVE_VALID;
  logic            RECEIVE_READY;
  logic [DW-1:0]   RECEIVE_DATA;
  logic [N-1:0]    SEND_VALID;
  logic [N-1:0]    SEND_READY;
  logic [DW*N-1:0] SEND_DATA;
  logic [15:0]     DROP_COUNT;

  logic            rr_small;
  logic [N-1:0]    sv_small;
  logic [DW*N-1:0] sd_small;
  logic [3:0]      dc_small;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  bit mon_en = 1'b0;
  logic [DW-1:0] exp_q [N][$];

  connect_split #(
    .DATA_WIDTH (DW),
    .CONNECT_NUM(N),
    .DEST_LSB   (0),
    .DEST_WIDTH (4),
    .CNT_WIDTH  (16)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RECEIVE_VALID(RECEIVE_VALID),
    .RECEIVE_READY(RECEIVE_READY),
    .RECEIVE_DATA (RECEIVE_DATA),
    .SEND_VALID   (SEND_VALID),
    .SEND_READY   (SEND_READY),
    .SEND_DATA    (SEND_DATA),
    .DROP_COUNT   (DROP_COUNT)
  );

  connect_split #(
    .DATA_WIDTH (DW),
    .CONNECT_NUM(N),
    .DEST_LSB   (0),
    .DEST_WIDTH (4),
    .CNT_WIDTH  (4)
  ) dut_small (
    .CLK          (CLK),
    .RST          (RST),
    .RECEIVE_VALID(RECEIVE_VALID),
    .RECEIVE_READY(rr_small),
    .RECEIVE_DATA (RECEIVE_DATA),
    .SEND_VALID   (sv_small),
    .SEND_READY   (SEND_READY),
    .SEND_DATA    (sd_small),
    .DROP_COUNT   (dc_small)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Output monitor: every handshake must match the head of that channel's queue.
  always @(negedge CLK) begin
    if (mon_en && !RST) begin
      for (int i = 0; i < N; i++) begin
        if (SEND_VALID[i] && SEND_READY[i]) begin
          logic [DW-1:0] exp;
          checks++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL unexpected_out ch%0d got %h expected none", i, SEND_DATA[DW*i +: DW]);
          end else begin
            exp = exp_q[i].pop_front();
            if (SEND_DATA[DW*i +: DW] !== exp) begin
              errors++;
              $display("FAIL out_data ch%0d got %h expected %h", i, SEND_DATA[DW*i +: DW], exp);
            end
          end
        end
      end
    end
  end

  task automatic flush_queues();
    for (int i = 0; i < N; i++) exp_q[i].delete();
  endtask

  // Present pkt until accepted; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [DW-1:0] pkt);
    int n = 0;
    int d;
    bit done = 1'b0;
    RECEIVE_VALID = 1'b1;
    RECEIVE_DATA  = pkt;
    d = int'(pkt[3:0]);
    while (!done) begin
      @(negedge CLK);
      if (RECEIVE_READY) begin
        if (d < N) exp_q[d].push_back(pkt);
        done = 1'b1;
      end else if (++n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout pkt %h got no ready expected ready", pkt);
        done = 1'b1;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    RECEIVE_VALID = 1'b0;
    @(posedge CLK);
    #1;
    flush_queues();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST           = 1'b1;
    RECEIVE_VALID = 1'($urandom);
    RECEIVE_DATA  = $urandom;
    SEND_READY    = 3'($urandom);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    checks++;
    if (SEND_VALID !== 3'b000) begin errors++; $display("FAIL reset_valid got %b expected 000", SEND_VALID); end
    checks++;
    if (DROP_COUNT !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d expected 0", DROP_COUNT); end
    checks++;
    if (RECEIVE_READY !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", RECEIVE_READY); end
    checks++;
    if (SEND_DATA !== '0) begin errors++; $display("FAIL reset_data got %h expected 0", SEND_DATA); end
    @(posedge CLK);
    #1;
    RST           = 1'b0;
    RECEIVE_VALID = 1'b0;
    SEND_READY    = 3'b111;
    @(negedge CLK);
    checks++;
    if (RECEIVE_READY !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b expected 1", RECEIVE_READY); end
    @(posedge CLK);
    #1;
    mon_en = 1'b1;
  endtask

  task automatic test_single_route();
    logic [DW-1:0] p;
    p = 32'hA5A5_0002;
    SEND_READY = 3'b000;
    send(p);
    RECEIVE_VALID = 1'b0;
    @(negedge CLK);
    checks++;
    if (SEND_VALID !== 3'b100) begin errors++; $display("FAIL route_valid got %b expected 100", SEND_VALID); end
    checks++;
    if (SEND_DATA[DW*2 +: DW] !== p) begin errors++; $display("FAIL route_data got %h expected %h", SEND_DATA[DW*2 +: DW], p); end
    @(posedge CLK);
    #1;
    SEND_READY = 3'b100;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    checks++;
    if (SEND_VALID !== 3'b000) begin errors++; $display("FAIL route_drain got %b expected 000", SEND_VALID); end
    @(posedge CLK);
    #1;
    SEND_READY = 3'b000;
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] p0, p1;
    p0 = 32'h1111_0001;
    p1 = 32'h2222_0001;
    SEND_READY = 3'b000;
    send(p0);
    fork
      send(p1);
      begin
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (RECEIVE_READY !== 1'b0) begin errors++; $display("FAIL bp_ready_blocked got %b expected 0", RECEIVE_READY); end
        checks++;
        if (SEND_VALID !== 3'b010 || SEND_DATA[DW +: DW] !== p0) begin
          errors++;
          $display("FAIL bp_hold got %b/%h expected 010/%h", SEND_VALID, SEND_DATA[DW +: DW], p0);
        end
        @(posedge CLK);
        #1;
        SEND_READY = 3'b010;
        @(negedge CLK);
        checks++;
        if (RECEIVE_READY !== 1'b1) begin errors++; $display("FAIL bp_ready_drain got %b expected 1", RECEIVE_READY); end
      end
    join
    RECEIVE_VALID = 1'b0;
    @(negedge CLK);
    checks++;
    if (SEND_VALID !== 3'b010 || SEND_DATA[DW +: DW] !== p1) begin
      errors++;
      $display("FAIL bp_second got %b/%h expected 010/%h", SEND_VALID, SEND_DATA[DW +: DW], p1);
    end
    @(posedge CLK);
    #1;
    @(negedge CLK);
    checks++;
    if (SEND_VALID !== 3'b000) begin errors++; $display("FAIL bp_empty got %b expected 000", SEND_VALID); end
    @(posedge CLK);
    #1;
    SEND_READY = 3'b000;
  endtask

  task automatic test_cross_channel();
    logic [DW-1:0] a, b;
    int unsigned c0;
    a = 32'hAAAA_0000;
    b = 32'hBBBB_0002;
    SEND_READY = 3'b000;
    send(a);
    SEND_READY = 3'b100;
    c0 = cyc;
    send(b);
    RECEIVE_VALID = 1'b0;
    checks++;
    if (cyc - c0 !== 1) begin errors++; $display("FAIL cross_latency got %0d expected 1", cyc - c0); end
    @(negedge CLK);
    checks++;
    if (SEND_VALID !== 3'b101) begin errors++; $display("FAIL cross_both got %b expected 101", SEND_VALID); end
    @(posedge CLK);
    #1;
    @(negedge CLK);
    checks++;
    if (SEND_VALID !== 3'b001 || SEND_DATA[0 +: DW] !== a) begin
      errors++;
      $display("FAIL cross_stall got %b/%h expected 001/%h", SEND_VALID, SEND_DATA[0 +: DW], a);
    end
    @(posedge CLK);
    #1;
    SEND_READY = 3'b111;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic test_streaming();
    int unsigned c0;
    SEND_READY = 3'b111;
    c0 = cyc;
    for (int k = 0; k < 100; k++) begin
      logic [DW-1:0] r;
      r = $urandom;
      send({r[DW-1:4], 4'(k % 3)});
    end
    RECEIVE_VALID = 1'b0;
    checks++;
    if (cyc - c0 !== 100) begin errors++; $display("FAIL stream_cycles got %0d expected 100", cyc - c0); end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic test_drop();
    do_reset();
    SEND_READY = 3'b111;
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) send(32'hDEAD_0007);
      else            send({24'($urandom), 4'h0, 4'(k % 3)});
    end
    RECEIVE_VALID = 1'b0;
    @(negedge CLK);
    checks++;
    if (DROP_COUNT !== 16'd5) begin errors++; $display("FAIL drop_count got %0d expected 5", DROP_COUNT); end
    checks++;
    if (dc_small !== 4'd5) begin errors++; $display("FAIL drop_count_small got %0d expected 5", dc_small); end
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 15; k++) begin
      send(32'hD0D0_000F - 32'(k % 4));
      RECEIVE_VALID = 1'b0;
      @(negedge CLK);
      checks++;
      if (SEND_VALID !== 3'b000) begin errors++; $display("FAIL drop_no_valid got %b expected 000", SEND_VALID); end
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    checks++;
    if (DROP_COUNT !== 16'd20) begin errors++; $display("FAIL drop_count20 got %0d expected 20", DROP_COUNT); end
    checks++;
    if (dc_small !== 4'd15) begin errors++; $display("FAIL drop_saturate got %0d expected 15", dc_small); end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_drained();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL leftover ch%0d got %0d pending expected 0", i, exp_q[i].size());
      end
    end
  endtask

  initial begin
    RST           = 1'b1;
    RECEIVE_VALID = 1'b0;
    RECEIVE_DATA  = '0;
    SEND_READY    = '0;
    test_reset();
    test_single_route();
    test_back_pressure();
    test_cross_channel();
    test_streaming();
    test_drained();
    test_drop();
    test_drained();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
